// File: rtl/sync_fifo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sync_fifo_pkg - shared widths and stream types for the sync FIFO family  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package sync_fifo_pkg;

  localparam int BUS_WIDTH         = 8;
  localparam int BURST_LEN_DEFAULT = 4;

  typedef struct packed {
    logic [BUS_WIDTH-1:0] data;
    logic                 last;
  } stream_word_t;

endpackage
`default_nettype wire

// File: rtl/skid_buf3.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | skid_buf3 - 3-entry circular buffer, head reads as zero when empty       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module skid_buf3
  import sync_fifo_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [BUS_WIDTH-1:0] push_data,
  input  logic                 pop,
  output logic [BUS_WIDTH-1:0] head_data,
  output logic [1:0]           occ
);

  logic [BUS_WIDTH-1:0] r_mem [3];
  logic [1:0]           r_head;
  logic [1:0]           r_tail;
  logic [1:0]           r_occ;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Callers guarantee push only with a free slot (or a same-cycle pop).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= 2'd0;
      r_tail <= 2'd0;
      r_occ  <= 2'd0;
      for (int i = 0; i < 3; i++) r_mem[i] <= '0;
    end else begin
      if (push) begin
        r_mem[r_tail] <= push_data;
        r_tail        <= ptr_inc(r_tail);
      end
      if (pop) r_head <= ptr_inc(r_head);
      r_occ <= r_occ + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head_data = (r_occ != 2'd0) ? r_mem[r_head] : '0;
  assign occ       = r_occ;

endmodule
`default_nettype wire

// File: rtl/fifo_stream_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_stream_reader - drains the sync FIFO read port onto a valid/ready   |
// | stream with burst-last marking and read-protocol error flag. Rev 1.0     |
// +--------------------------------------------------------------------------+
module fifo_stream_reader
  import sync_fifo_pkg::*;
#(
  parameter int BURST_LEN = BURST_LEN_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  input  logic [BUS_WIDTH-1:0] fifo_data,
  input  logic                 fifo_valid,
  output logic [BUS_WIDTH-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last,
  output logic                 protocol_err
);

  localparam int                 c_CNT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(BURST_LEN - 1);

  logic [1:0]           w_occ;
  logic [BUS_WIDTH-1:0] w_head_data;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_push;
  logic                 w_err_set;
  stream_word_t         w_head;

  logic                 r_inflight;
  logic [c_CNT_W-1:0]   r_burst_cnt;
  logic                 r_err;

  // Registered terms only, so m_ready never reaches the FIFO strobe.
  assign fifo_rd_en = enable && !fifo_empty &&
                      (({1'b0, w_occ} + {2'b00, r_inflight}) <= 3'd2);

  assign m_valid   = (w_occ != 2'd0);
  assign w_pop     = m_valid && m_ready;
  assign w_full    = (w_occ == 2'd3);
  assign w_push    = fifo_valid && (!w_full || w_pop);
  assign w_err_set = fifo_valid && (!r_inflight || (w_full && !w_pop));

  always_comb begin
    w_head      = '0;
    w_head.data = w_head_data;
    w_head.last = m_valid && (r_burst_cnt == c_LAST_CNT);
  end

  assign m_data       = w_head.data;
  assign m_last       = w_head.last;
  assign protocol_err = r_err;

  skid_buf3 u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (fifo_data),
    .pop       (w_pop),
    .head_data (w_head_data),
    .occ       (w_occ)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight  <= 1'b0;
      r_burst_cnt <= '0;
      r_err       <= 1'b0;
    end else begin
      r_inflight <= fifo_rd_en;
      r_err      <= r_err | w_err_set;
      if (w_pop) r_burst_cnt <= (r_burst_cnt == c_LAST_CNT) ? '0 : r_burst_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fifo_stream_reader - directed and random stimulus against a queue     |
// | model of the FIFO, skid buffer and burst framing. Rev 1.0                |
// +--------------------------------------------------------------------------+
module tb_fifo_stream_reader;
  import sync_fifo_pkg::*;

  localparam int BL = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 enable = 1'b0;
  logic                 fifo_empty = 1'b1;
  logic                 fifo_rd_en;
  logic [BUS_WIDTH-1:0] fifo_data = '0;
  logic                 fifo_valid = 1'b0;
  logic [BUS_WIDTH-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready = 1'b0;
  logic                 m_last;
  logic                 protocol_err;

  always #5 clk = ~clk;

  fifo_stream_reader #(.BURST_LEN(BL)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_data    (fifo_data),
    .fifo_valid   (fifo_valid),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_last       (m_last),
    .protocol_err (protocol_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO contents, buffered words, read in flight, pops since reset.
  logic [BUS_WIDTH-1:0] fifoq[$];
  logic [BUS_WIDTH-1:0] sbq[$];
  bit                   inflight_m;
  bit                   err_m;
  int                   pops_m;

  // Observations of the DUT.
  logic [BUS_WIDTH-1:0] outq[$];
  logic [BUS_WIDTH-1:0] lasts[$];
  logic [BUS_WIDTH-1:0] expq[$];
  int obs_rd, obs_mv, cyc, first_rd, first_mv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    outq.delete();
    lasts.delete();
    obs_rd = 0; obs_mv = 0; cyc = 0; first_rd = -1; first_mv = -1;
  endtask

  task automatic cycle();
    bit exp_rd, exp_pop;
    fifo_empty = (fifoq.size() == 0);
    @(negedge clk);
    exp_rd  = enable && (fifoq.size() > 0) && (sbq.size() + int'(inflight_m) <= 2);
    exp_pop = (sbq.size() > 0) && m_ready;
    check("rd_en",   fifo_rd_en,   exp_rd);
    check("m_valid", m_valid,      sbq.size() > 0);
    check("m_data",  m_data,       (sbq.size() > 0) ? sbq[0] : '0);
    check("m_last",  m_last,       (sbq.size() > 0) && (pops_m % BL == BL - 1));
    check("perr",    protocol_err, err_m);
    if (fifo_rd_en) begin
      obs_rd++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (m_valid) begin
      obs_mv++;
      if (first_mv < 0) first_mv = cyc;
    end
    if (m_valid && m_ready) begin
      outq.push_back(m_data);
      if (m_last) lasts.push_back(m_data);
    end
    cyc++;
    @(posedge clk);
    #1;
    if (exp_pop) begin
      void'(sbq.pop_front());
      pops_m++;
    end
    if (fifo_valid) begin
      if (!inflight_m) err_m = 1'b1;
      if (sbq.size() < 3) sbq.push_back(fifo_data);
      else err_m = 1'b1;
    end
    inflight_m = exp_rd;
    if (exp_rd) begin
      fifo_data  = fifoq.pop_front();
      fifo_valid = 1'b1;
    end else begin
      fifo_data  = BUS_WIDTH'($urandom);
      fifo_valid = 1'b0;
    end
    fifo_empty = (fifoq.size() == 0);
  endtask

  // Asserts reset mid-cycle and checks the outputs clear without a clock edge.
  task automatic do_reset();
    enable = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst m_valid", m_valid, 1'b0);
    check("rst m_data",  m_data,  '0);
    check("rst m_last",  m_last,  1'b0);
    check("rst perr",    protocol_err, 1'b0);
    sbq.delete();
    inflight_m = 1'b0;
    err_m      = 1'b0;
    pops_m     = 0;
    fifo_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic preload(input logic [BUS_WIDTH-1:0] base);
    for (int i = 0; i < 8; i++) fifoq.push_back(BUS_WIDTH'(base + BUS_WIDTH'(i)));
  endtask

  initial begin
    fifoq.delete();
    do_reset();

    // Straight-through stream with burst marking.
    preload(8'h11);
    enable = 1'b1; m_ready = 1'b1;
    clear_obs();
    repeat (14) cycle();
    check("t1 latency", first_mv - first_rd, 2);
    check("t1 count", outq.size(), 8);
    for (int i = 0; i < outq.size(); i++) check("t1 data", outq[i], 8'h11 + i);
    check("t1 nlast", lasts.size(), 2);
    if (lasts.size() == 2) begin
      check("t1 last0", lasts[0], 8'h14);
      check("t1 last1", lasts[1], 8'h18);
    end

    // Backpressure fills the buffer then stops reads.
    do_reset();
    preload(8'h21);
    enable = 1'b1; m_ready = 1'b0;
    clear_obs();
    repeat (10) cycle();
    check("t2 rd pulses", obs_rd, 3);
    check("t2 occ", dut.w_occ, 3);
    m_ready = 1'b1;
    repeat (14) cycle();
    check("t2 count", outq.size(), 8);
    for (int i = 0; i < outq.size(); i++) check("t2 data", outq[i], 8'h21 + i);

    // Enable dropped right after a read issue; stream then resumes in alignment.
    preload(8'h31);
    enable = 1'b1; m_ready = 1'b1;
    clear_obs();
    for (int k = 0; k < 5 && obs_rd == 0; k++) cycle();
    enable = 1'b0;
    obs_rd = 0;
    repeat (6) cycle();
    check("t3 no rd", obs_rd, 0);
    check("t3 inflight word n", outq.size(), 1);
    if (outq.size() > 0) check("t3 inflight word", outq[0], 8'h31);
    enable = 1'b1;
    repeat (14) cycle();
    check("t3 count", outq.size(), 8);
    for (int i = 0; i < outq.size(); i++) check("t3 data", outq[i], 8'h31 + i);
    check("t3 nlast", lasts.size(), 2);
    if (lasts.size() == 2) begin
      check("t3 last0", lasts[0], 8'h34);
      check("t3 last1", lasts[1], 8'h38);
    end

    // Single word in the FIFO.
    fifoq.push_back(8'h41);
    clear_obs();
    repeat (6) cycle();
    check("t4 rd pulses", obs_rd, 1);
    check("t4 mv cycles", obs_mv, 1);
    if (outq.size() > 0) check("t4 data", outq[0], 8'h41);

    // Unsolicited fifo_valid sets a sticky error.
    enable = 1'b0;
    repeat (2) cycle();
    clear_obs();
    fifo_valid = 1'b1; fifo_data = 8'hAA;
    repeat (6) cycle();
    check("t5 perr", protocol_err, 1'b1);
    check("t5 word n", outq.size(), 1);
    if (outq.size() > 0) check("t5 word", outq[0], 8'hAA);
    do_reset();

    // Reset with two buffered words and one in flight.
    preload(8'h61);
    enable = 1'b1; m_ready = 1'b0;
    repeat (3) cycle();
    check("t6 occ", dut.w_occ, 2);
    check("t6 inflight", dut.r_inflight, 1'b1);
    do_reset();
    enable = 1'b1; m_ready = 1'b1;
    clear_obs();
    repeat (12) cycle();
    check("t6 count", outq.size(), 5);
    if (outq.size() > 0) check("t6 first", outq[0], 8'h64);
    if (lasts.size() > 0) check("t6 last", lasts[0], 8'h67);

    // fifo_valid in the first cycle after reset release.
    do_reset();
    m_ready = 1'b1;
    fifo_valid = 1'b1; fifo_data = 8'h5A;
    repeat (3) cycle();
    check("t7 perr", protocol_err, 1'b1);

    // Random enable, backpressure and FIFO fill.
    do_reset();
    fifoq.delete();
    expq.delete();
    clear_obs();
    repeat (400) begin
      enable  = ($urandom_range(0, 3) != 0);
      m_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 2) == 0) begin
        logic [BUS_WIDTH-1:0] w;
        w = BUS_WIDTH'($urandom);
        fifoq.push_back(w);
        expq.push_back(w);
      end
      cycle();
    end
    enable = 1'b1; m_ready = 1'b1;
    for (int k = 0; k < 300 && (fifoq.size() > 0 || sbq.size() > 0); k++) cycle();
    repeat (3) cycle();
    check("t8 count", outq.size(), expq.size());
    for (int i = 0; i < outq.size() && i < expq.size(); i++) check("t8 data", outq[i], expq[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
